uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer_pkg.sv | 29 ++
 rtl/uart_tx_parity_gen.sv | 18 +
 rtl/uart_tx_serializer.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared state encoding, frame bundle and defaults for the UART TX serializer.
package uart_tx_serializer_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int FIFO_LAT_DEF   = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       bit8;
      logic       parity_en;
      logic       odd_n_even;
   } tx_frame_t;

   function automatic logic [2:0] last_data_bit(
      input logic bit8
   );
      return bit8 ? 3'd7 : 3'd6;
   endfunction

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Parity over the transmitted data bits; bit 7 drops out in 7-bit mode.
module uart_tx_parity_gen (
   input  logic [7:0] data,
   input  logic       bit8,
   input  logic       odd_n_even,
   output logic       parity
);

   logic [7:0] sent;

   always_comb begin
      sent = data;
      if (!bit8) sent[7] = 1'b0;
   end

   assign parity = (^sent) ^ odd_n_even;

endmodule

// File: rtl/uart_tx_serializer.sv
// Pulls bytes from a TX FIFO and shifts them out as UART frames.
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int FIFO_LAT   = FIFO_LAT_DEF
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       baud_tick,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_n,
   output logic       tx,
   output logic       tx_busy
);

   localparam int TCW = $clog2(OVERSAMPLE);
   localparam int LCW = $clog2(FIFO_LAT + 2);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
   localparam logic [LCW-1:0] LAT_LAST  = LCW'(FIFO_LAT);

   tx_state_e      state;
   tx_state_e      state_nx;
   logic [TCW-1:0] tick_cnt;
   logic [TCW-1:0] tick_nx;
   logic [2:0]     bit_cnt;
   logic [2:0]     bit_nx;
   logic [2:0]     bit_inc;
   logic [LCW-1:0] lat_cnt;
   logic [LCW-1:0] lat_nx;
   tx_frame_t      frame;
   tx_frame_t      frame_nx;
   logic           loaded;
   logic           loaded_nx;
   logic           armed;
   logic           tx_nx;
   logic           read_n_nx;
   logic           in_bit;
   logic           bit_done;
   logic           parity;

   uart_tx_parity_gen u_parity (
      .data       (frame.data),
      .bit8       (frame.bit8),
      .odd_n_even (frame.odd_n_even),
      .parity     (parity)
   );

   // armed holds off the first read until one edge after reset release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         lat_cnt     <= '0;
         frame       <= '0;
         loaded      <= 1'b0;
         armed       <= 1'b0;
         tx          <= 1'b1;
         fifo_read_n <= 1'b1;
         tx_busy     <= 1'b0;
      end else begin
         state       <= state_nx;
         tick_cnt    <= tick_nx;
         bit_cnt     <= bit_nx;
         lat_cnt     <= lat_nx;
         frame       <= frame_nx;
         loaded      <= loaded_nx;
         armed       <= 1'b1;
         tx          <= tx_nx;
         fifo_read_n <= read_n_nx;
         tx_busy     <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx  = state;
      tick_nx   = tick_cnt;
      bit_nx    = bit_cnt;
      lat_nx    = lat_cnt;
      frame_nx  = frame;
      loaded_nx = loaded;
      tx_nx     = tx;
      read_n_nx = 1'b1;
      bit_inc   = bit_cnt + 3'd1;
      in_bit    = (state == START)
               || (state == DATA)
               || (state == PARITY)
               || (state == STOP);
      bit_done  = in_bit && baud_tick
               && (tick_cnt == TICK_LAST);

      if (in_bit && baud_tick) tick_nx = tick_cnt + 1'b1;
      if (bit_done) tick_nx = '0;

      unique case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (armed && !fifo_empty) begin
               read_n_nx = 1'b0;
               state_nx  = FETCH;
               lat_nx    = '0;
               loaded_nx = 1'b0;
            end
         end
         FETCH: begin
            if (!loaded) begin
               if (lat_cnt == LAT_LAST) begin
                  frame_nx.data       = fifo_data;
                  frame_nx.bit8       = bit8;
                  frame_nx.parity_en  = parity_en;
                  frame_nx.odd_n_even = odd_n_even;
                  loaded_nx           = 1'b1;
               end else begin
                  lat_nx = lat_cnt + 1'b1;
               end
            end else if (baud_tick) begin
               state_nx = START;
               tick_nx  = '0;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_nx = DATA;
               bit_nx   = '0;
               tx_nx    = frame.data[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_cnt == last_data_bit(frame.bit8)) begin
                  if (frame.parity_en) begin
                     state_nx = PARITY;
                     tx_nx    = parity;
                  end else begin
                     state_nx = STOP;
                     tx_nx    = 1'b1;
                  end
               end else begin
                  bit_nx = bit_inc;
                  tx_nx  = frame.data[bit_inc];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_nx = STOP;
               tx_nx    = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_nx = IDLE;
               tx_nx    = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Random and directed frames against a bit-list model of the UART frame.
module tb_uart_tx_serializer;

   localparam int OS  = 16;
   localparam int LAT = 3;

   typedef struct {
      logic [7:0] data;
      logic       b8;
      logic       pe;
      logic       odd;
   } item_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       baud_tick = 1'b0;
   logic       bit8 = 1'b0;
   logic       parity_en = 1'b0;
   logic       odd_n_even = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_read_n;
   logic       tx;
   logic       tx_busy;

   uart_tx_serializer #(
      .OVERSAMPLE (OS),
      .FIFO_LAT   (LAT)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .baud_tick   (baud_tick),
      .bit8        (bit8),
      .parity_en   (parity_en),
      .odd_n_even  (odd_n_even),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_read_n (fifo_read_n),
      .tx          (tx),
      .tx_busy     (tx_busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   item_t fifo_q[$];
   item_t exp_q[$];
   item_t cur;

   int cyc = 0;
   int since = -1;
   int n_reads = 0;
   int rd_empty = 0;
   int rd_long = 0;
   int edge_err = 0;
   int stop_cyc = 0;
   int frames_done = 0;
   int pos = 0;
   int n_exp = 0;
   int unstable = 0;
   int busy_bad = 0;
   int last_n = 0;
   logic gap_pend = 1'b0;
   logic prev_busy = 1'b0;
   logic prev_rd_low = 1'b0;
   logic prev_tx = 1'b1;
   logic prev_t = 1'b0;
   logic mon_active = 1'b0;
   logic [11:0] exp_bits;
   logic [11:0] obs_bits;
   logic [11:0] last_obs = '0;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic item_t mk(
      input logic [7:0] d,
      input logic       b8,
      input logic       pe,
      input logic       odd
   );
      item_t it;
      it.data = d;
      it.b8   = b8;
      it.pe   = pe;
      it.odd  = odd;
      return it;
   endfunction

   // Expected line levels: start, LSB-first data, optional parity, stop.
   task automatic build(input item_t e);
      int nb;
      int ones;
      nb = e.b8 ? 8 : 7;
      ones = 0;
      exp_bits = '1;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < nb; i++) begin
         exp_bits[i+1] = e.data[i];
         ones += int'(e.data[i]);
      end
      n_exp = nb + 1;
      if (e.pe) begin
         exp_bits[n_exp] = ((ones % 2) == 1) ^ e.odd;
         n_exp++;
      end
      exp_bits[n_exp] = 1'b1;
      n_exp++;
   endtask

   task automatic sample();
      int b;
      logic [11:0] mask;
      if (!mon_active && tx === 1'b0) begin
         check("frame_expected", 32'(exp_q.size()), 1);
         if (exp_q.size() > 0) begin
            build(exp_q.pop_front());
            mon_active = 1'b1;
            pos = 0;
            unstable = 0;
            busy_bad = 0;
            obs_bits = '1;
         end
      end
      if (mon_active) begin
         b = pos / OS;
         if (pos % OS == 0) obs_bits[b] = tx;
         else if (tx !== obs_bits[b]) unstable++;
         if (tx_busy !== 1'b1) busy_bad++;
         pos++;
         if (pos == n_exp * OS) begin
            mask = (12'h1 << n_exp) - 12'h1;
            check("frame_bits", 32'(obs_bits & mask), 32'(exp_bits & mask));
            check("bit_stable", unstable, 0);
            check("busy_in_frame", busy_bad, 0);
            last_obs = obs_bits;
            last_n = n_exp;
            frames_done++;
            mon_active = 1'b0;
         end
      end
   endtask

   // One clock: FIFO model, tick source and line monitor, all at negedge.
   task automatic cycle();
      logic t;
      @(negedge clock);
      cyc++;
      t = ($urandom_range(0, 1) == 1);
      if (!reset_n) begin
         since = -1;
         gap_pend = 1'b0;
         mon_active = 1'b0;
         prev_tx = 1'b1;
         prev_busy = 1'b0;
      end else begin
         if (tx !== prev_tx && !prev_t) edge_err++;
         prev_tx = tx;
         if (prev_busy && !tx_busy) begin
            stop_cyc = cyc;
            gap_pend = (fifo_q.size() > 0);
         end
         prev_busy = tx_busy;
         if (since >= 0) since = (since < LAT) ? since + 1 : -1;
         if (fifo_read_n === 1'b0) begin
            n_reads++;
            if (fifo_empty) rd_empty++;
            if (prev_rd_low) rd_long++;
            if (gap_pend) begin
               check("b2b_gap", 32'(cyc - stop_cyc <= LAT + OS + 2), 1);
               gap_pend = 1'b0;
            end
            if (fifo_q.size() > 0) begin
               cur = fifo_q.pop_front();
               exp_q.push_back(cur);
            end
            since = 0;
         end
         if (t) sample();
      end
      prev_rd_low = (fifo_read_n === 1'b0);
      prev_t = t;
      baud_tick = t;
      if (since == LAT) begin
         fifo_data = cur.data;
         bit8 = cur.b8;
         parity_en = cur.pe;
         odd_n_even = cur.odd;
      end else begin
         fifo_data = 8'($urandom);
         bit8 = 1'($urandom);
         parity_en = 1'($urandom);
         odd_n_even = 1'($urandom);
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while ((frames_done < target || tx_busy || fifo_q.size() > 0)
             && n < 20000) begin
         cycle();
         n++;
      end
      check("frames_done", frames_done, target);
   endtask

   initial begin
      int first;
      int n;
      int r0;
      int fd0;
      int v_rd;
      int v_tx;
      int v_busy;

      #1 reset_n = 1'b0;
      cycle();
      cycle();
      check("rst_tx", 32'(tx), 1);
      check("rst_read_n", 32'(fifo_read_n), 1);
      check("rst_busy", 32'(tx_busy), 0);

      fifo_q.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0));
      cycle();
      reset_n = 1'b1;
      first = 0;
      for (int k = 1; k <= 6; k++) begin
         cycle();
         if (first == 0 && fifo_read_n === 1'b0) first = k;
      end
      check("first_read_late", 32'(first >= 2), 1);
      wait_frames(1);
      check("f55_len", last_n, 10);
      check("f55_bits", 32'(last_obs[9:0]), 32'h2AA);

      fifo_q.push_back(mk(8'h03, 1'b1, 1'b1, 1'b1));
      wait_frames(frames_done + 1);
      check("p03_odd_len", last_n, 11);
      check("p03_odd_par", 32'(last_obs[9]), 1);
      fifo_q.push_back(mk(8'h03, 1'b1, 1'b1, 1'b0));
      wait_frames(frames_done + 1);
      check("p03_even_par", 32'(last_obs[9]), 0);

      fifo_q.push_back(mk(8'h80, 1'b0, 1'b0, 1'b0));
      wait_frames(frames_done + 1);
      check("f80_len", last_n, 9);
      check("f80_bits", 32'(last_obs[8:0]), 32'h100);

      r0 = n_reads;
      fifo_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
      fifo_q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
      wait_frames(frames_done + 2);
      check("b2b_reads", n_reads - r0, 2);

      for (int g = 0; g < 8; g++) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++)
            fifo_q.push_back(mk(8'($urandom), 1'($urandom),
                                1'($urandom), 1'($urandom)));
         wait_frames(frames_done + n);
         repeat ($urandom_range(0, 40)) cycle();
      end

      fd0 = frames_done;
      fifo_q.push_back(mk(8'hF0, 1'b1, 1'b1, 1'b0));
      n = 0;
      while (!(mon_active && pos >= 4 * OS + 2) && n < 4000) begin
         cycle();
         n++;
      end
      check("reach_bit3",
            32'(mon_active && pos >= 4 * OS + 2 && pos < 5 * OS), 1);
      check("pre_rst_tx", 32'(tx), 0);
      fifo_q.push_back(mk(8'h5A, 1'b1, 1'b1, 1'b1));
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx), 1);
      check("mid_rst_busy", 32'(tx_busy), 0);
      v_rd = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (fifo_read_n !== 1'b1) v_rd++;
      end
      check("mid_rst_no_read", v_rd, 0);
      reset_n = 1'b1;
      wait_frames(fd0 + 1);

      v_rd = 0;
      v_tx = 0;
      v_busy = 0;
      for (int k = 0; k < 1000; k++) begin
         cycle();
         if (fifo_read_n !== 1'b1) v_rd++;
         if (tx !== 1'b1) v_tx++;
         if (tx_busy !== 1'b0) v_busy++;
      end
      check("idle_read_n", v_rd, 0);
      check("idle_tx", v_tx, 0);
      check("idle_busy", v_busy, 0);

      check("read_when_empty", rd_empty, 0);
      check("read_pulse_width", rd_long, 0);
      check("tx_off_tick_edge", edge_err, 0);
      check("frames_left", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
